// File: rtl/right_shift_seq.sv
// Multi-cycle right shifter: one shift-amount bit per cycle, logical or arithmetic fill.
// Fixed latency of clog2(width) cycles between the accept edge and o_valid.
module right_shift_seq #(
    parameter int unsigned width = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [width-1:0]         iBits,
    input  logic [$clog2(width)-1:0] shift,
    input  logic                     arith,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [width-1:0]         oBits
);

    localparam int unsigned stages = $clog2(width);
    localparam int unsigned kw     = $clog2(stages + 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e              state_q, state_d;
    logic [width-1:0]    data_q, data_d;
    logic [stages-1:0]   amt_q, amt_d;
    logic                fill_q, fill_d;
    logic [kw-1:0]       k_q, k_d;

    logic                amt_bit;
    int unsigned         step;
    logic [width-1:0]    ones;
    logic [width-1:0]    fill_mask;
    logic [width-1:0]    stage_out;

    // Shifting by step >= width yields zero data and an all-ones mask, i.e. all-fill.
    always_comb begin
        ones      = '1;
        step      = 32'd1 << k_q;
        fill_mask = ~(ones >> step);
        stage_out = (data_q >> step) | (fill_q ? fill_mask : '0);
        amt_bit   = 1'b0;
        for (int j = 0; j < int'(stages); j++) begin
            if (k_q == kw'(j)) amt_bit = amt_q[j];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    data_d  = iBits;
                    amt_d   = shift;
                    fill_d  = arith & iBits[width-1];
                    k_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (amt_bit) data_d = stage_out;
                k_d = k_q + kw'(1);
                if (k_q == kw'(stages - 1)) state_d = StHold;
            end
            StHold: begin
                if (o_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            k_q     <= k_d;
        end
    end

    assign i_ready = (state_q == StIdle);
    assign o_valid = (state_q == StHold);
    assign oBits   = data_q;

endmodule

// File: tb/tb_right_shift_seq.sv
// Directed and random-stream bench for right_shift_seq at width=8 (3 shift stages).
module tb_right_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] iBits;
    logic [2:0] shift;
    logic       arith;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] oBits;

    int checks;
    int failures;

    right_shift_seq #(.width(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .iBits   (iBits),
        .shift   (shift),
        .arith   (arith),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .oBits   (oBits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] b, input logic [2:0] s,
                                         input logic a);
        logic signed [7:0] sb;
        sb = $signed(b);
        if (a) return 8'(sb >>> s);
        return b >> s;
    endfunction

    // Present one transaction at a negedge; returns at the negedge after the accept edge.
    task automatic start(input string tag, input logic [7:0] b, input logic [2:0] s,
                         input logic a);
        iBits   = b;
        shift   = s;
        arith   = a;
        i_valid = 1'b1;
        chk({tag, "_iready"}, i_ready, 1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        chk({tag, "_ovalid_early"}, o_valid, 0);
    endtask

    task automatic wait_valid(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_obits"}, oBits, exp);
        chk({tag, "_iready_low"}, i_ready, 0);
    endtask

    task automatic run(input string tag, input logic [7:0] b, input logic [2:0] s,
                       input logic a, input logic [7:0] exp);
        start(tag, b, s, a);
        wait_valid(tag, exp);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_ovalid"}, o_valid, 0);
        chk({tag, "_done_iready"}, i_ready, 1);
    endtask

    logic [7:0] q[$];
    logic [7:0] cur_bits;
    logic [2:0] cur_sh;
    logic       cur_ar;
    logic [7:0] exp_v;
    int         sent;
    int         got;
    int         cyc;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        iBits    = 8'h00;
        shift    = 3'd0;
        arith    = 1'b0;
        o_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_iready", i_ready, 1);
        chk("rst_ovalid", o_valid, 0);
        chk("rst_obits", oBits, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        run("lsr3", 8'hB4, 3'd3, 1'b0, 8'h16);
        run("asr3_neg", 8'hB4, 3'd3, 1'b1, 8'hF6);
        run("asr3_pos", 8'h34, 3'd3, 1'b1, 8'h06);
        run("sh0", 8'h5A, 3'd0, 1'b0, 8'h5A);
        run("asr7", 8'h80, 3'd7, 1'b1, 8'hFF);
        run("lsr7", 8'h80, 3'd7, 1'b0, 8'h01);

        // Backpressure in HOLD with stray i_valid pulses.
        o_ready = 1'b0;
        start("bp", 8'hB4, 3'd3, 1'b0);
        wait_valid("bp", 8'h16);
        for (int c = 0; c < 5; c++) begin
            i_valid = c[0];
            iBits   = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_obits", oBits, 8'h16);
            chk("bp_hold_ovalid", o_valid, 1);
            chk("bp_hold_iready", i_ready, 0);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ovalid", o_valid, 0);
        chk("bp_release_iready", i_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_ghost", i_ready, 1);

        // Reset during the second SHIFT cycle.
        start("rst_shift", 8'hB4, 3'd0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_shift_ovalid", o_valid, 0);
        chk("rst_shift_obits", oBits, 8'h00);
        chk("rst_shift_iready", i_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in HOLD drops o_valid asynchronously.
        o_ready = 1'b0;
        start("rst_hold", 8'hC3, 3'd1, 1'b1);
        wait_valid("rst_hold", 8'hE1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold_ovalid", o_valid, 0);
        chk("rst_hold_obits", oBits, 8'h00);
        @(negedge clk);
        rst_n   = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        run("after_rst", 8'hF0, 3'd4, 1'b0, 8'h0F);

        // Random stream with random backpressure against the model.
        sent     = 0;
        got      = 0;
        cyc      = 0;
        cur_bits = 8'($urandom);
        cur_sh   = 3'($urandom);
        cur_ar   = 1'($urandom);
        while (got < 50 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            o_ready = ($urandom_range(0, 3) != 0);
            i_valid = (sent < 50) && ($urandom_range(0, 4) != 0);
            iBits   = cur_bits;
            shift   = cur_sh;
            arith   = cur_ar;
            if (o_valid && o_ready) begin
                chk("stream_nonempty", q.size() != 0, 1);
                exp_v = (q.size() != 0) ? q.pop_front() : 8'h00;
                chk("stream_result", oBits, exp_v);
                got++;
            end
            if (i_valid && i_ready) begin
                q.push_back(model(cur_bits, cur_sh, cur_ar));
                sent++;
                cur_bits = 8'($urandom);
                cur_sh   = 3'($urandom);
                cur_ar   = 1'($urandom);
            end
        end
        i_valid = 1'b0;
        chk("stream_count", got, 50);
        chk("stream_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
